// File: rtl/pwm_compare.sv
// pwm_compare: turns the live count of a free-running up-counter into a
// registered PWM waveform. The duty value is double-buffered: writes land in
// a pending register and only reach the comparator at a counter wrap, so a
// period already under way is never cut short or stretched.
module pwm_compare #(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] cnt,
  input  logic [N:0]   duty_in,
  input  logic         duty_wr,
  output logic         pwm_out,
  output logic         pending,
  output logic         period_done,
  output logic [M-1:0] periods
);

  logic [N-1:0] cnt_q;
  logic [N:0]   duty_act;
  logic [N:0]   duty_pend;
  logic [N:0]   duty_eff;
  logic         wrap;

  // A wrap is the count arriving at zero from a nonzero value, so a stalled
  // counter, or one parked at zero after reset, never looks like a new period.
  assign wrap = (cnt == '0) && (cnt_q != '0);

  // The first cycle of a new period already compares against the value being
  // committed, so the new duty covers the whole period from count zero.
  assign duty_eff = (wrap && pending) ? duty_pend : duty_act;

  // All state: previous count, duty double buffer, PWM compare, period pulse
  // and period counter. A write in the same cycle as a commit runs after it,
  // so the new value waits for the following wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      duty_act    <= '0;
      duty_pend   <= '0;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      periods     <= '0;
    end else begin
      cnt_q       <= cnt;
      pwm_out     <= ({1'b0, cnt} < duty_eff);
      period_done <= wrap;
      if (wrap) begin
        periods <= periods + {{(M-1){1'b0}}, 1'b1};
      end
      if (wrap && pending) begin
        duty_act <= duty_pend;
        pending  <= 1'b0;
      end
      if (duty_wr) begin
        duty_pend <= duty_in;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pwm_compare.md
Name: pwm_compare

Overview:
Downstream consumer of the N-bit free-running up-counter. It compares the live count against a double-buffered duty value and produces a registered PWM waveform, a one-cycle period-boundary pulse and a running period count. Duty updates are accepted at any time but only take effect at a counter wrap, so no PWM period is ever glitched.

Parameters:
N, 4, counter width; must match the width of the up-counter feeding cnt.
M, 8, width of the period counter output.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
cnt  input  N  live count from the up-counter; treated as synchronous to clk.
duty_in  input  N+1  requested high-time in counts; 0..2^N inclusive.
duty_wr  input  1  write strobe; captures duty_in into the pending register.
pwm_out  output  1  registered PWM output.
pending  output  1  high while a written duty value awaits the next wrap.
period_done  output  1  one-cycle pulse, one cycle after a detected wrap.
periods  output  M  number of wraps since reset, modulo 2^M.

Behaviour:
- Reset is synchronous, active-high, and dominates every other input in the same edge.
- Reset values: pwm_out=0, pending=0, period_done=0, periods=0, internal cnt_q=0, duty_act=0, duty_pend=0.
- cnt_q is a register holding cnt from the previous cycle.
- Wrap event W (combinational) = (cnt == 0) AND (cnt_q != 0).
  - A stalled counter (cnt unchanged) never produces W.
  - Counter sitting at 0 out of reset produces no W; the first W is the first 2^N-1 -> 0 transition, or any nonzero -> 0 transition.
- Effective duty: duty_eff = duty_pend when (W AND pending), else duty_act.
- Commit: on W with pending=1, duty_act <= duty_pend and pending <= 0, unless duty_wr is also asserted (see below).
- Write: on duty_wr, duty_pend <= duty_in and pending <= 1.
- Simultaneous W and duty_wr:
  - The old duty_pend (if pending) is committed to duty_act.
  - The new duty_in lands in duty_pend.
  - pending stays or becomes 1.
  - The new value applies at the following wrap, never the current one.
- Back-to-back writes without a wrap: last write wins; pending stays 1.
- pwm_out <= (zero-extended cnt < duty_eff). Latency is 1 cycle from cnt to pwm_out.
  - duty 0 gives constant low.
  - duty 2^N gives constant high.
  - duty d gives d high cycles per 2^N-cycle period, provided the counter is free-running.
- period_done <= W (one-cycle pulse, 1 cycle after the cycle in which cnt reads 0).
- periods <= periods + 1 on W; wraps from 2^M-1 to 0 with no saturation.
- Counter stall: pwm_out keeps tracking the compare against the held cnt; no duty commit and no period_done while stalled.
- Reset mid-period:
  - The pending write is discarded and duty_act returns to 0.
  - pwm_out is low on the next cycle.
  - cnt_q=0, so the counter's next nonzero -> 0 transition is the first W.

Test Plan:
1. Reset with N=4, free-running cnt, duty_wr=1 with duty_in=5 in the cycle cnt=3 -> pending=1 next cycle. Wrap at cnt 15->0 -> pwm_out high for cnt 0..4 (observed one cycle later), low for cnt 5..15. pending=0 and period_done pulses once. periods=1.
2. duty_in=0, then a wrap -> pwm_out constantly low. duty_in=16, then a wrap -> pwm_out constantly high over a full 16-cycle period.
3. duty_wr with duty_in=9 asserted in the exact cycle cnt=0 (W true), with an earlier pending value 3 -> the period just starting uses 3 high cycles. The next period uses 9. pending stays 1 until the second wrap.
4. Writes 2, 7, 12 on consecutive cycles mid-period -> the next period shows 12 high cycles; no intermediate value ever appears on pwm_out.
5. Counter enable held low for 20 cycles at cnt=6 with duty 8 -> pwm_out holds 1, no period_done, periods unchanged. After release, the normal wrap increments periods by 1.
6. Assert reset at cnt=10 with pending=1 -> next cycle pwm_out=0, pending=0, periods=0. The subsequent wrap does not apply the discarded value, and pwm_out stays low (duty_act=0).
